// File: rtl/bus_fault_arb_pkg.sv
// Shared types and helpers for the bus-fault report arbiter.
// Holds the FSM state encoding and width helpers.
package bus_fault_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } state_t;

    localparam int DROP_W = 8;

    function automatic int src_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_fault_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
// The pointer itself is owned and advanced by the parent.
module rr_arbiter
    import bus_fault_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    localparam int SW = src_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SW-1:0]    ptr,
    input  logic             en,
    output logic             gnt_valid,
    output logic [SW-1:0]    gnt_idx
);

    int w_idx;

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = 0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N_SRC) begin
                w_idx = w_idx - N_SRC;
            end
            if (en && req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/bus_fault_arbiter.sv
// Buffers one fault report per source and forwards them round-robin
// to the interrupt controller's single bad-address port.
module bus_fault_arbiter
    import bus_fault_arb_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 15,
    localparam int SW = src_w(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        flt_pulse,
    input  logic [N_SRC*ADDR_W-1:0] flt_addr,
    input  logic                    err_pending,
    output logic [ADDR_W-1:0]       out_addr,
    output logic                    out_valid,
    input  logic                    out_ack,
    output logic [SW-1:0]           out_src,
    output logic [N_SRC-1:0]        overflow,
    output logic                    timeout_flag,
    output logic [DROP_W-1:0]       drop_count,
    input  logic                    flags_clr
);

    localparam logic [7:0] TO_CNT = 8'(ACK_TIMEOUT);

    state_t              r_state;
    logic [N_SRC-1:0]    r_full;
    logic [ADDR_W-1:0]   r_slot [N_SRC];
    logic [SW-1:0]       r_ptr;
    logic [7:0]          r_cnt;

    logic                w_en;
    logic                w_gnt_valid;
    logic [SW-1:0]       w_gnt_idx;
    logic                w_ack_rel;
    logic                w_to_rel;
    logic [N_SRC-1:0]    w_free;
    logic [N_SRC-1:0]    w_drop;
    logic [3:0]          w_drop_n;
    logic [DROP_W-1:0]   w_dc_base;
    logic [DROP_W:0]     w_dc_sum;
    logic [DROP_W-1:0]   w_dc_next;

    assign w_en      = (r_state == IDLE) && !err_pending;
    assign w_ack_rel = (r_state == WAIT_ACK) && out_ack;
    assign w_to_rel  = (r_state == WAIT_ACK) && !out_ack
                       && (r_cnt == TO_CNT);
    assign w_drop    = flt_pulse & r_full & ~w_free;

    always_comb begin
        w_free = '0;
        if (w_ack_rel || w_to_rel) begin
            w_free[out_src] = 1'b1;
        end
    end

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_drop_n = w_drop_n + {3'b000, w_drop[i]};
        end
    end

    // A clear in the same cycle as new drops restarts from those drops.
    assign w_dc_base = flags_clr ? '0 : drop_count;
    assign w_dc_sum  = {1'b0, w_dc_base}
                     + {{(DROP_W - 3){1'b0}}, w_drop_n};
    assign w_dc_next = w_dc_sum[DROP_W] ? '1 : w_dc_sum[DROP_W-1:0];

    rr_arbiter #(
        .N_SRC (N_SRC)
    ) u_rr (
        .req       (r_full),
        .ptr       (r_ptr),
        .en        (w_en),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (flt_pulse[i] && (!r_full[i] || w_free[i])) begin
                    r_full[i] <= 1'b1;
                    r_slot[i] <= flt_addr[i*ADDR_W +: ADDR_W];
                end else if (w_free[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            out_addr  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        out_addr  <= r_slot[w_gnt_idx];
                        out_src   <= w_gnt_idx;
                        out_valid <= 1'b1;
                        r_ptr     <= (int'(w_gnt_idx) == N_SRC - 1)
                                     ? '0 : w_gnt_idx + 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    out_valid <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (w_ack_rel || w_to_rel) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow     <= '0;
            timeout_flag <= 1'b0;
            drop_count   <= '0;
        end else begin
            overflow     <= (flags_clr ? '0 : overflow) | w_drop;
            timeout_flag <= (flags_clr ? 1'b0 : timeout_flag) | w_to_rel;
            drop_count   <= w_dc_next;
        end
    end

endmodule
